// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: valid/ready channel carrying received words from uart_rx_ctrl
// to the APB-side receive logic.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer (start/data/[parity]/stop sampling, word handoff).
// Define UART_RX_PARITY_EN to build the parity bit state and parity check.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           rst,
    input  logic           start_edge,
    input  logic           rx_s,
    uart_rx_ctrl_if.master rd,
    output logic           busy,
    output logic           frame_err,
    output logic           parity_err,
    output logic           overrun
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_ctrl: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_rx_ctrl: DATA_BITS must be 5..8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_rx_ctrl: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sample;

    assign sample = (cnt == '0);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
    logic par_acc;
    logic par_pend;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc     <= 1'b0;
            par_pend    <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc     <= 1'b0;
            par_pend    <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A load at stop completion below overrides this consume-clear.
            if (rd.rd_valid && rd.rd_ready) begin
                rd.rd_valid <= 1'b0;
            end

            if (state != IDLE && state != WAIT_IDLE) begin
                cnt <= sample ? CNT_BIT : cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
`ifdef UART_RX_PARITY_EN
                            par_acc  <= 1'b0;
                            par_pend <= 1'b0;
`endif
                        end
                    end
                end

                DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                        par_acc <= par_acc ^ rx_s;
`endif
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_pend <= (rx_s != (par_acc ^ PAR_ODD_BIT));
                        state    <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_pend;
`endif
                            if (rd.rd_valid && !rd.rd_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                rd.rd_data  <= shreg;
                                rd.rd_valid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer. It is triggered by the one-cycle `start_edge` pulse from the RX start-edge detector and sequences the bit-timing counter through start, data, optional parity and stop sampling on the synchronized `rx` line. It assembles the received word and hands it to the APB-side receive logic over a valid/ready handshake, reporting framing, parity and overrun errors.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit. Must be at least 4. Half-bit is HALF = CLKS_PER_BIT/2, integer division.
- `DATA_BITS`, default 8: data bits per frame, legal range 5 to 8.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Used only when parity is compiled in.

- `clk`  in  1: clock.
- `arst`  in  1: reset, asynchronous, active-low.
- `rst`  in  1: synchronous reset, active-high. Same effect as `arst`.
- `start_edge`  in  1: one-cycle falling-edge pulse from the edge detector.
- `rx_s`  in  1: synchronized serial line, aligned with `start_edge`.
- `rd_ready`  in  1: consumer accepts `rd_data` this cycle.
- `rd_data`  out  DATA_BITS: received word, LSB is the first bit on the line.
- `rd_valid`  out  1: `rd_data` holds an unconsumed word.
- `busy`  out  1: FSM is not in IDLE.
- `frame_err`  out  1: one-cycle pulse, stop bit sampled low.
- `parity_err`  out  1: one-cycle pulse, parity mismatch.
- `overrun`  out  1: one-cycle pulse, a completed frame was dropped.

## Operation
- Reset (`arst` or `rst`) forces: state IDLE; `rd_data`=0; `rd_valid`=0; `busy`=0; all error pulses 0; bit counter and index 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - `start_edge`=1 → START; load bit counter with HALF-1.
  - `start_edge` is ignored in every other state.
- In all timed states, the counter decrements each cycle. Reaching 0 is a sample point, after which the counter reloads with CLKS_PER_BIT-1.
- START sample:
  - `rx_s`=1 → false start. Return to IDLE with no flags raised.
  - `rx_s`=0 → DATA with index 0.
- DATA sample: shift `rx_s` in, LSB first. After the sample with index DATA_BITS-1, go to PARITY (if compiled in) or STOP.
- PARITY sample: the expected bit is the XOR of the data bits, XORed with `PARITY_ODD`. On mismatch, latch a pending parity error. Then go to STOP.
- STOP sample:
  - `rx_s`=1 → frame complete. A pending parity error is pulsed on `parity_err` and the word is still delivered. Go to IDLE.
  - `rx_s`=0 → pulse `frame_err` and discard the word. Go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then IDLE. A break condition therefore produces exactly one `frame_err`.
- Output handshake:
  - A word transfers when `rd_valid` and `rd_ready` are both 1.
  - `rd_data` is stable while `rd_valid`=1.
  - When a frame completes with `rd_valid`=1 and `rd_ready`=0: pulse `overrun`, drop the new word, keep the old word.
  - When a frame completes in the same cycle as a transfer: load the new word and keep `rd_valid`=1. No overrun.

## Timing
- Cycle 0 is the cycle in which `start_edge` is seen high in IDLE.
- `busy` rises at cycle 1.
- Sample points (P = 1 if parity is compiled in, else 0):
  - start bit: cycle HALF;
  - data bit k: cycle HALF + (k+1)·CLKS_PER_BIT;
  - parity bit: cycle HALF + (DATA_BITS+1)·CLKS_PER_BIT;
  - stop bit: cycle HALF + (DATA_BITS+1+P)·CLKS_PER_BIT.
- Error pulses, `rd_valid`/`rd_data` update and the return to IDLE (`busy`=0) all take effect the cycle after the stop sample.
- After a good stop bit, a new `start_edge` is accepted from the next cycle.
- Reset asserted mid-frame aborts the frame immediately with no flags raised. A word already waiting in `rd_data` is lost.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state and parity check are built;
  - each frame is 1 + DATA_BITS + 1 + 1 bits long.
- `UART_RX_PARITY_EN` undefined:
  - no PARITY state;
  - `parity_err` is tied to 0;
  - `PARITY_ODD` is ignored;
  - frames are 1 + DATA_BITS + 1 bits long.

## Test plan
All cases use CLKS_PER_BIT=16 and DATA_BITS=8, with parity disabled unless stated.
- Byte 0xA5 with `rd_ready`=1 → `rd_valid`=1 with `rd_data`=0xA5 at cycle 153, and `busy`=0 at cycle 153.
- Glitch: `start_edge` pulse with `rx_s` back high by cycle 8 → return to IDLE at cycle 9, no `rd_valid`, no flags.
- Byte 0x3C with stop bit low, line then held low for 40 cycles → exactly one `frame_err` pulse at cycle 153, no `rd_valid`. The next `start_edge` is ignored until `rx_s` is high.
- Two bytes 0x11 and 0x22 with `rd_ready`=0 → `rd_data` stays 0x11 and `overrun` pulses once at the second completion. Repeat with `rd_ready` pulsed in the completion cycle → `rd_data`=0x22, no overrun.
- `UART_RX_PARITY_EN` with even parity, byte 0x07 sent with parity bit 0 → `parity_err` pulse at cycle 169 and `rd_data`=0x07 delivered. With parity bit 1 → no error.
- `arst` low at cycle 60 of a frame → all outputs 0 immediately, and a clean next frame is received correctly.
